// File: rtl/qnigma_inet_cks_if.sv
// qnigma_inet_cks_if: payload, control and result signals of the checksum engine.
// master = packet source / result consumer, slave = checksum engine.
// QNIGMA_CKS_VERIFY_EN adds the cks_ok receive-verify flag.
interface qnigma_inet_cks_if #(
  parameter int W_BYTES = 2,
  parameter int ACC_W   = 32
);
  logic                   clr;
  logic [15:0]            seed;
  logic                   vin;
  logic [8*W_BYTES-1:0]   din;
  logic [W_BYTES-1:0]     kin;
  logic                   lst;
  logic                   ful;
  logic                   bsy;
  logic [ACC_W-1:0]       sum;
  logic [15:0]            cks;
  logic                   cks_val;
`ifdef QNIGMA_CKS_VERIFY_EN
  logic                   cks_ok;

  modport master (
    output clr, seed, vin, din, kin, lst, ful,
    input  bsy, sum, cks, cks_val, cks_ok
  );
  modport slave (
    input  clr, seed, vin, din, kin, lst, ful,
    output bsy, sum, cks, cks_val, cks_ok
  );
`else
  modport master (
    output clr, seed, vin, din, kin, lst, ful,
    input  bsy, sum, cks, cks_val
  );
  modport slave (
    input  clr, seed, vin, din, kin, lst, ful,
    output bsy, sum, cks, cks_val
  );
`endif
endinterface

// File: rtl/qnigma_inet_cks.sv
// qnigma_inet_cks: RFC 1071 ones-complement checksum engine.
// Sums W_BYTES bytes per beat with packet-position byte placement, folds
// carries in two cycles, then strobes ~folded sum on cks/cks_val.
// Optional macro QNIGMA_CKS_VERIFY_EN adds registered cks_ok (folded == FFFF).

// One byte lane: places a kept byte in the high or low half of a 16-bit word.
module qnigma_inet_cks_lane (
  input  logic [7:0]  byt,
  input  logic        keep,
  input  logic        odd,
  output logic [15:0] word
);
  // even packet position -> high byte, odd -> low byte, dropped byte -> 0
  always_comb begin
    word = 16'h0000;
    if (keep) word = odd ? {8'h00, byt} : {byt, 8'h00};
  end
endmodule

module qnigma_inet_cks #(
  parameter int W_BYTES = 2,
  parameter int ACC_W   = 32
) (
  input logic             clk,
  input logic             rst,
  qnigma_inet_cks_if.slave bus
);
  localparam logic [1:0] ST_ACC   = 2'd0;
  localparam logic [1:0] ST_FOLD1 = 2'd1;
  localparam logic [1:0] ST_FOLD2 = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]                 state;
  logic [ACC_W-1:0]           acc;
  logic                       par;       // 1 = next byte lands at odd position
  logic [15:0]                cks_q;
  logic                       cks_val_q;

  logic                       bsy;
  logic                       acc_in;
  logic                       par_base;
  logic                       nxt_par;
  logic [W_BYTES-1:0][7:0]    lane_byt;
  logic [W_BYTES-1:0]         lane_keep;
  logic [W_BYTES-1:0]         lane_odd;
  logic [W_BYTES-1:0][15:0]   lane_word;
  logic [ACC_W-1:0]           beat_sum;
  logic [ACC_W-1:0]           fold;

  // parity of the keep bits in lanes below n (lane 0 is the first wire byte)
  function automatic logic pre_par(input logic [W_BYTES-1:0] k, input int n);
    logic r;
    r = 1'b0;
    for (int j = 0; j < W_BYTES; j++)
      if (j < n) r = r ^ k[j];
    return r;
  endfunction

  assign bsy    = (state != ST_ACC);
  assign acc_in = bus.vin && !bus.ful && !bsy;

  // a clr beat starts a fresh packet, so its first byte is at even position
  assign par_base = bus.clr ? 1'b0 : par;
  assign nxt_par  = par_base ^ (^lane_keep);

  generate
    for (genvar i = 0; i < W_BYTES; i++) begin : g_lane
      assign lane_byt[i]  = bus.din[8*W_BYTES-1-8*i -: 8];
      assign lane_keep[i] = bus.kin[W_BYTES-1-i];
      assign lane_odd[i]  = par_base ^ pre_par(lane_keep, i);

      qnigma_inet_cks_lane u_lane (
        .byt  (lane_byt[i]),
        .keep (lane_keep[i]),
        .odd  (lane_odd[i]),
        .word (lane_word[i])
      );
    end
  endgenerate

  // all lanes of a beat are added in one cycle
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < W_BYTES; i++)
      beat_sum = beat_sum + ACC_W'(lane_word[i]);
  end

  // end-around carry fold; two passes always fit the result in 16 bits
  assign fold = ACC_W'(acc[15:0]) + ACC_W'(acc[ACC_W-1:16]);

  // packet FSM: accumulate, fold twice, publish; clr restarts from any state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ACC;
      acc       <= '0;
      par       <= 1'b0;
      cks_q     <= 16'hFFFF;
      cks_val_q <= 1'b0;
    end else begin
      cks_val_q <= 1'b0;
      if (bus.clr) begin
        // a result already folded in DONE is still published
        if (state == ST_DONE) begin
          cks_q     <= ~acc[15:0];
          cks_val_q <= 1'b1;
        end
        acc   <= ACC_W'(bus.seed) + (acc_in ? beat_sum : '0);
        par   <= acc_in ? nxt_par : 1'b0;
        state <= (acc_in && bus.lst) ? ST_FOLD1 : ST_ACC;
      end else begin
        case (state)
          ST_ACC: begin
            if (acc_in) begin
              acc <= acc + beat_sum;
              par <= nxt_par;
              if (bus.lst) state <= ST_FOLD1;
            end
          end
          ST_FOLD1: begin
            acc   <= fold;
            state <= ST_FOLD2;
          end
          ST_FOLD2: begin
            acc   <= fold;
            state <= ST_DONE;
          end
          ST_DONE: begin
            cks_q     <= ~acc[15:0];
            cks_val_q <= 1'b1;
            state     <= ST_ACC;
          end
          default: state <= ST_ACC;
        endcase
      end
    end
  end

  assign bus.bsy     = bsy;
  assign bus.sum     = acc;
  assign bus.cks     = cks_q;
  assign bus.cks_val = cks_val_q;

`ifdef QNIGMA_CKS_VERIFY_EN
  logic ok_q;

  // received packet is valid when its folded sum is all ones
  always_ff @(posedge clk) begin
    if (rst)                    ok_q <= 1'b0;
    else if (state == ST_DONE)  ok_q <= (acc[15:0] == 16'hFFFF);
    else if (bus.clr)           ok_q <= 1'b0;
  end

  assign bus.cks_ok = ok_q;
`endif
endmodule

// File: doc/qnigma_inet_cks.md
# qnigma_inet_cks

Parametrised RFC 1071 ones-complement checksum engine for the qnigma network stack. It accepts a multi-byte payload stream with per-byte keep and optional pseudo-header seed. It tracks byte parity across beats, folds carries, and presents a finished 16-bit checksum with a valid strobe. It generalises the single-byte echo checksum accumulator for use by the ICMP, UDP and TCP TX/RX paths.

## Interface
Parameters:
- `W_BYTES`, 2, bytes per input beat; legal values are 1, 2 and 4.
- `ACC_W`, 32, accumulator width; must be ≥ 17 and at least large enough for 65535 bytes without overflow.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `clr` in 1: start new packet; loads `seed` into the accumulator and clears parity.
- `seed` in 16: initial sum, e.g. a precomputed pseudo-header sum.
- `vin` in 1: input beat valid.
- `din` in 8*W_BYTES: data; byte 0 is `din[8*W_BYTES-1 -:8]` (MSB first on the wire).
- `kin` in W_BYTES: byte keep; contiguous from MSB; all ones except possibly on the last beat or the first beat.
- `lst` in 1: last beat of packet; qualified by an accepted beat.
- `ful` in 1: downstream FIFO full; a beat is accepted only when `vin && !ful && !bsy`.
- `bsy` out 1: folding in progress; beats are ignored.
- `sum` out ACC_W: raw unfolded accumulator.
- `cks` out 16: final checksum, equal to ~folded sum.
- `cks_val` out 1: one-cycle strobe when `cks` is valid.
- `cks_ok` out 1: only present with the macro; see Configuration.

## Operation
- **States:** ACC, FOLD1, FOLD2, DONE.
  - Reset state is ACC with accumulator 0 and parity even.
- **ACC:**
  - Each accepted beat walks the kept bytes in order.
  - A byte at even packet position is added as `{byte,8'h00}`; at odd position as `{8'h00,byte}`.
  - Parity toggles per kept byte. All bytes of one beat are summed in the same cycle.
  - An accepted beat with `lst=1` moves to FOLD1 after the beat's addition.
- **FOLD1:** acc ← `acc[15:0] + acc[ACC_W-1:16]`.
- **FOLD2:** same fold operation again; the result now fits in 16 bits.
- **DONE:** `cks` ← ~acc[15:0]; `cks_val`=1 for one cycle; then return to ACC.
  - Accumulator and `cks` are held until `clr` or `rst`. A new packet requires `clr`.
- `bsy`=1 in FOLD1, FOLD2 and DONE.
- **`clr` priority:**
  - `clr` overrides everything except `rst`, in any state, including aborting a fold. No `cks_val` is issued for an aborted fold.
  - `clr` with an accepted beat: acc ← seed + beat contribution, with parity starting even.
  - `clr` with `lst` behaves as a one-beat packet.
- **Stall:** `vin` with `ful`=1 causes no state, parity or accumulator change; the beat is not consumed.
- `kin`=0 on an accepted beat adds nothing. If `lst`=1 is set on it, the beat still finishes the packet.
- A zero-length packet (`clr` then a `lst` beat with `kin`=0) yields `cks` = ~seed.

## Timing
- Accumulator updates on the clock edge after an accepted beat; `sum` is registered.
- `cks_val` rises 3 cycles after the edge that accepts the `lst` beat: 1 cycle each for FOLD1, FOLD2 and DONE.
- Throughput is one beat per cycle while in ACC. The next packet's `clr` is allowed in the DONE cycle or later.
- **Reset values:**
  - `sum`=0, `cks`=16'hFFFF, `cks_val`=0, `bsy`=0, `cks_ok`=0.
  - Parity is even and state is ACC.
- `rst` mid-packet or mid-fold returns to the reset values on the next edge.

## Configuration
- **`QNIGMA_CKS_VERIFY_EN` defined:**
  - Adds output `cks_ok`, registered and updated in DONE: 1 if the folded sum equals 16'hFFFF, i.e. a received packet including its checksum field is valid.
  - `cks_ok` holds until the next `clr`/`rst`, which clear it to 0.
- **Not defined:** the `cks_ok` port and its logic are absent; all other behaviour is identical.

## Test plan
- W_BYTES=2, seed 0: beats 4500, 001C with `lst` on the second → `sum`=0x451C; `cks`=0xBAE3 exactly 3 cycles later; `cks_val` high 1 cycle.
- W_BYTES=1, odd length: bytes 01 02 03 with `lst` → `cks`=0xFBFD.
- W_BYTES=2, carry fold: FFFF, FFFF → `sum`=0x1FFFE, `cks`=0x0000. With the macro defined, then run FFFF, 0000 → `cks`=0x0000 and `cks_ok`=1.
- W_BYTES=2, misaligned: beat AB?? with `kin`=10, then CDEF with `kin`=11 and `lst` → `cks`=0x6531. Insert `ful`=1 for 2 cycles between the beats → identical result, latency counted from acceptance.
- W_BYTES=4: 01020304 with `kin`=1111, then 05xxxxxx with `kin`=1000 and `lst` → `cks`=0xF6F9. Repeat with seed=0x0011 → `cks`=0xF6E8.
- **Abort/reset:**
  - Assert `clr` during FOLD1 → no `cks_val`, `sum`=seed.
  - Assert `rst` mid-packet → `sum`=0, `cks`=0xFFFF, `bsy`=0 next cycle.
